// File: rtl/board_pkg.sv
// Shared board constants: highlight mode encodings and default cell geometry
// for a 3x3 board drawn on an XGA-sized raster.
package board_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_SOLID  = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_BORDER = 2'd3
    } mode_t;

    localparam int COORD_W          = 12;
    localparam int GRID_N_DEF       = 3;
    localparam int ORIGIN_X_DEF     = 1;
    localparam int ORIGIN_Y_DEF     = 3;
    localparam int CELL_W_DEF       = 339;
    localparam int CELL_H_DEF       = 249;
    localparam int PITCH_X_DEF      = 342;
    localparam int PITCH_Y_DEF      = 256;
    localparam int BORDER_W_DEF     = 8;
    localparam int BLINK_FRAMES_DEF = 30;
    localparam logic [11:0] HL_COLOR_DEF = 12'hff0;

    // Inclusive range test on unsigned coordinates.
    function automatic logic in_span(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/frame_blinker.sv
// Per-frame timing: vsync rising-edge strobe, frame counter and blink phase.
// Entering BLINK restarts the sequence with the highlight visible.
module frame_blinker #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic pclk,
    input  logic rst,
    input  logic vsync_in,
    input  logic enter_blink,
    output logic frame_start,
    output logic blink_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             vsync_prev_r;
    logic [CNT_W-1:0] frame_cnt_r;
    logic             blink_phase_r;

    assign frame_start = vsync_in & ~vsync_prev_r;
    assign blink_phase = blink_phase_r;

    // Previous-cycle vsync for edge detection.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vsync_prev_r <= 1'b0;
        end else begin
            vsync_prev_r <= vsync_in;
        end
    end

    // Frame counter and blink phase, advanced once per frame.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (frame_start) begin
            if (enter_blink) begin
                frame_cnt_r   <= '0;
                blink_phase_r <= 1'b1;
            end else if (frame_cnt_r == CNT_LAST) begin
                frame_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            frame_cnt_r   <= frame_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end

endmodule

// File: rtl/draw_cell_highlight.sv
// Two-stage video overlay that highlights one board cell (solid, blinking or
// border) on a passing raster; cell and mode are sampled once per frame.
module draw_cell_highlight
    import board_pkg::*;
#(
    parameter int GRID_N       = GRID_N_DEF,
    parameter int ORIGIN_X     = ORIGIN_X_DEF,
    parameter int ORIGIN_Y     = ORIGIN_Y_DEF,
    parameter int CELL_W       = CELL_W_DEF,
    parameter int CELL_H       = CELL_H_DEF,
    parameter int PITCH_X      = PITCH_X_DEF,
    parameter int PITCH_Y      = PITCH_Y_DEF,
    parameter int BORDER_W     = BORDER_W_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF,
    parameter logic [11:0] HL_COLOR = HL_COLOR_DEF
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [3:0]  cell_sel,
    input  logic [1:0]  mode,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    logic [3:0]  sel_r;
    mode_t       mode_r;
    logic        frame_start_s;
    logic        blink_phase_s;
    logic        enter_blink_s;

    logic [COORD_W-1:0] sel_s, row_s, col_s, x_s, y_s;
    logic [COORD_W-1:0] x0_s, x1_s, y0_s, y1_s;
    logic               sel_valid_s, inside_s, edge_s, hl_s;

    logic [10:0] hcount_r, vcount_r;
    logic        hsync_r, hblnk_r, vsync_r, vblnk_r, hl_r;
    logic [11:0] rgb_r;

    assign enter_blink_s = (mode_t'(mode) == MODE_BLINK) && (mode_r != MODE_BLINK);

    frame_blinker #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_frame_blinker (
        .pclk        (pclk),
        .rst         (rst),
        .vsync_in    (vsync_in),
        .enter_blink (enter_blink_s),
        .frame_start (frame_start_s),
        .blink_phase (blink_phase_s)
    );

    // Shadow copies of cell/mode, so a frame never changes mid-scan.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            sel_r  <= 4'd0;
            mode_r <= MODE_OFF;
        end else if (frame_start_s) begin
            sel_r  <= cell_sel;
            mode_r <= mode_t'(mode);
        end else begin
            sel_r  <= sel_r;
            mode_r <= mode_r;
        end
    end

    // Cell bounds and per-pixel hit decision for the current mode.
    always_comb begin
        sel_s       = {8'd0, sel_r};
        row_s       = sel_s / COORD_W'(GRID_N);
        col_s       = sel_s % COORD_W'(GRID_N);
        x0_s        = COORD_W'(ORIGIN_X) + col_s * COORD_W'(PITCH_X);
        y0_s        = COORD_W'(ORIGIN_Y) + row_s * COORD_W'(PITCH_Y);
        x1_s        = x0_s + COORD_W'(CELL_W - 1);
        y1_s        = y0_s + COORD_W'(CELL_H - 1);
        x_s         = {1'b0, hcount_in};
        y_s         = {1'b0, vcount_in};
        sel_valid_s = sel_s < COORD_W'(GRID_N * GRID_N);
        inside_s    = sel_valid_s && in_span(x_s, x0_s, x1_s) && in_span(y_s, y0_s, y1_s);
        // Right/bottom tests add to the pixel rather than subtract from the
        // far edge so a narrow cell cannot underflow.
        edge_s      = (x_s < x0_s + COORD_W'(BORDER_W)) ||
                      (x_s + COORD_W'(BORDER_W) > x1_s) ||
                      (y_s < y0_s + COORD_W'(BORDER_W)) ||
                      (y_s + COORD_W'(BORDER_W) > y1_s);
        hl_s        = 1'b0;
        case (mode_r)
            MODE_OFF:    hl_s = 1'b0;
            MODE_SOLID:  hl_s = inside_s;
            MODE_BLINK:  hl_s = inside_s && blink_phase_s;
            MODE_BORDER: hl_s = inside_s && edge_s;
            default:     hl_s = 1'b0;
        endcase
    end

    // Stage 1: timing, colour and hit flag aligned together.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_r <= 11'd0;
            vcount_r <= 11'd0;
            hsync_r  <= 1'b0;
            hblnk_r  <= 1'b0;
            vsync_r  <= 1'b0;
            vblnk_r  <= 1'b0;
            rgb_r    <= 12'd0;
            hl_r     <= 1'b0;
        end else begin
            hcount_r <= hcount_in;
            vcount_r <= vcount_in;
            hsync_r  <= hsync_in;
            hblnk_r  <= hblnk_in;
            vsync_r  <= vsync_in;
            vblnk_r  <= vblnk_in;
            rgb_r    <= rgb_in;
            hl_r     <= hl_s;
        end
    end

    // Stage 2: colour mux; blanking always passes the source colour.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= 12'd0;
        end else begin
            hcount_out <= hcount_r;
            vcount_out <= vcount_r;
            hsync_out  <= hsync_r;
            hblnk_out  <= hblnk_r;
            vsync_out  <= vsync_r;
            vblnk_out  <= vblnk_r;
            if (hl_r && !hblnk_r && !vblnk_r) begin
                rgb_out <= HL_COLOR;
            end else begin
                rgb_out <= rgb_r;
            end
        end
    end

endmodule

// File: tb/tb_draw_cell_highlight.sv
// Directed self-checking bench for draw_cell_highlight (default geometry,
// BLINK_FRAMES=2) with hand-computed pixel expectations.
module tb_draw_cell_highlight;

    localparam logic [11:0] HL = 12'hff0;

    logic        pclk = 1'b0;
    logic        rst  = 1'b0;
    logic [10:0] hcount_in = 11'd0;
    logic [10:0] vcount_in = 11'd0;
    logic        hsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] rgb_in = 12'd0;
    logic [3:0]  cell_sel = 4'd0;
    logic [1:0]  mode = 2'd0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    int checks = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    draw_cell_highlight #(
        .BLINK_FRAMES (2)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .cell_sel   (cell_sel),
        .mode       (mode),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic new_frame();
        vsync_in = 1'b0;
        step();
        vsync_in = 1'b1;
        step();
        vsync_in = 1'b0;
        step();
    endtask

    task automatic pix(input string tag, input int x, input int y,
                       input logic [11:0] c, input logic exp_hl);
        hcount_in = 11'(x);
        vcount_in = 11'(y);
        rgb_in    = c;
        repeat (2) step();
        check_eq(tag, 32'(rgb_out), exp_hl ? 32'(HL) : 32'(c));
    endtask

    initial begin
        logic [10:0] hv [6];
        logic [5:0]  blink_pat;

        #1 rst = 1'b1;
        #2;
        check_eq("reset_rgb", 32'(rgb_out), 32'd0);
        check_eq("reset_timing", {6'd0, hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}, 32'd0);
        step();
        step();
        rst = 1'b0;

        // No highlight before the first vsync rising edge.
        mode = 2'd1;
        cell_sel = 4'd5;
        pix("pre_vsync", 700, 300, 12'h123, 1'b0);

        new_frame();
        pix("solid_tl", 685, 259, 12'h123, 1'b1);
        pix("solid_br", 1023, 507, 12'h234, 1'b1);
        pix("solid_left_out", 684, 259, 12'h345, 1'b0);
        pix("solid_right_out", 1024, 507, 12'h456, 1'b0);

        mode = 2'd3;
        cell_sel = 4'd0;
        new_frame();
        pix("border_corner", 1, 3, 12'h111, 1'b1);
        pix("border_left", 8, 100, 12'h222, 1'b1);
        pix("border_inner", 9, 100, 12'h333, 1'b0);
        pix("border_center", 170, 130, 12'h444, 1'b0);
        pix("border_bottom", 170, 251, 12'h555, 1'b1);

        mode = 2'd1;
        cell_sel = 4'd3;
        new_frame();
        pix("sel3_hit", 100, 300, 12'h0a1, 1'b1);
        cell_sel = 4'd7;
        pix("sel3_still", 100, 300, 12'h0a2, 1'b1);
        pix("sel7_not_yet", 400, 600, 12'h0a3, 1'b0);
        new_frame();
        pix("sel7_hit", 400, 600, 12'h0a4, 1'b1);
        pix("sel3_gone", 100, 300, 12'h0a5, 1'b0);
        cell_sel = 4'd9;
        new_frame();
        pix("sel9_none", 400, 600, 12'h0a6, 1'b0);
        pix("sel9_none_c0", 1, 3, 12'h0a7, 1'b0);

        cell_sel = 4'd4;
        new_frame();
        pix("sel4_hit", 400, 300, 12'h0b1, 1'b1);
        hblnk_in = 1'b1;
        pix("hblnk_pass", 400, 300, 12'h0b2, 1'b0);
        hblnk_in = 1'b0;
        vblnk_in = 1'b1;
        pix("vblnk_pass", 400, 300, 12'h0b3, 1'b0);
        vblnk_in = 1'b0;

        // Two-cycle latency of the timing signals.
        for (int i = 0; i < 6; i++) begin
            hv[i]     = 11'(i * 37 + 5);
            hcount_in = hv[i];
            vcount_in = hv[i] + 11'd1;
            hsync_in  = i[0];
            hblnk_in  = i[1];
            step();
            if (i >= 1) begin
                check_eq("dly_hcount", 32'(hcount_out), 32'(hv[i-1]));
                check_eq("dly_vcount", 32'(vcount_out), 32'(hv[i-1] + 11'd1));
                check_eq("dly_sync", {30'd0, hsync_out, hblnk_out}, {30'd0, ((i - 1) & 1) != 0, ((i - 1) & 2) != 0});
            end
        end
        hsync_in = 1'b0;
        hblnk_in = 1'b0;

        // Blink with 2-frame half period: on, on, off, off, on, on.
        mode = 2'd2;
        cell_sel = 4'd4;
        blink_pat = 6'b110011;
        for (int f = 0; f < 6; f++) begin
            new_frame();
            pix("blink_frame", 400, 300, 12'h0c0 + 12'(f), blink_pat[5 - f]);
        end

        // Asynchronous reset between clock edges.
        mode = 2'd1;
        hsync_in = 1'b1;
        pix("pre_reset_hit", 500, 400, 12'h456, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_rgb", 32'(rgb_out), 32'd0);
        check_eq("async_rst_hcount", 32'(hcount_out), 32'd0);
        check_eq("async_rst_hsync", 32'(hsync_out), 32'd0);
        #1;
        rst = 1'b0;
        hsync_in = 1'b0;
        step();
        pix("post_rst_nohl", 400, 300, 12'h789, 1'b0);
        new_frame();
        pix("post_rst_vsync_hl", 400, 300, 12'h78a, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
